// File: rtl/scnn_act_compressor_if.sv
// Output stream of the activation compressor: one non-zero activation and its
// coordinates per transfer.
interface scnn_act_compressor_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6,
  parameter int RC_W   = 3
);
  // valid/ready: a transfer happens on every rising edge where out_valid and
  // out_ready are both high. Once out_valid rises, out_val/idx/row/col hold
  // steady and out_valid stays high until that transfer (reset excepted).
  // out_ready may change freely and never depends on out_valid.
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_val;
  logic [IDX_W-1:0]  out_idx;
  logic [RC_W-1:0]   out_row;
  logic [RC_W-1:0]   out_col;

  modport master (
    output out_valid, out_val, out_idx, out_row, out_col,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_val, out_idx, out_row, out_col,
    output out_ready
  );
endinterface

// File: rtl/scnn_act_compressor.sv
// Captures a dense activation plane and streams its non-zero entries, with
// linear index and (row, col), one element examined per cycle.
module scnn_act_compressor #(
  parameter int PARAM_IP_SIZE = 64,
  parameter int PARAM_IP_DIM  = 8,
  parameter int PARAM_DATA_W  = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [PARAM_IP_SIZE-1:0][PARAM_DATA_W-1:0] input_acts,
  input  logic [7:0]                                input_dim,
  output logic                                      busy,
  output logic                                      done,
  output logic [$clog2(PARAM_IP_SIZE+1)-1:0]        nnz_count,
  output logic [1:0]                                state_dbg,
  scnn_act_compressor_if.master                     out_if
);
  localparam int IDX_W = $clog2(PARAM_IP_SIZE);
  localparam int RC_W  = $clog2(PARAM_IP_DIM);
  localparam int CNT_W = $clog2(PARAM_IP_SIZE + 1);
  localparam int DIM_W = $clog2(PARAM_IP_DIM + 1);
  localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(PARAM_IP_DIM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PARAM_IP_SIZE-1:0][PARAM_DATA_W-1:0] r_buf;
  logic [DIM_W-1:0]        r_dim;
  logic [IDX_W-1:0]        r_idx;
  logic [RC_W-1:0]         r_row;
  logic [RC_W-1:0]         r_col;
  logic [CNT_W-1:0]        r_nnz;

  logic                    r_valid;
  logic [PARAM_DATA_W-1:0] r_val;
  logic [IDX_W-1:0]        r_out_idx;
  logic [RC_W-1:0]         r_out_row;
  logic [RC_W-1:0]         r_out_col;

  logic [DIM_W-1:0]        w_start_dim;
  logic [PARAM_DATA_W-1:0] w_elem;
  logic                    w_nz;
  logic                    w_slot_free;
  logic                    w_col_wrap;
  logic                    w_last;
  logic                    w_capture;
  logic                    w_examine;
  logic                    w_drain_clear;

  // Planes wider than the buffer are clamped to the largest supported edge.
  assign w_start_dim = (input_dim > 8'(PARAM_IP_DIM)) ? MAX_DIM : input_dim[DIM_W-1:0];

  assign w_elem      = r_buf[r_idx];
  assign w_nz        = (w_elem != '0);
  assign w_slot_free = !r_valid || out_if.out_ready;
  assign w_col_wrap  = (DIM_W'(r_col) == (r_dim - DIM_W'(1)));
  assign w_last      = w_col_wrap && (DIM_W'(r_row) == (r_dim - DIM_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_examine     = 1'b0;
    w_drain_clear = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = (w_start_dim == '0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_slot_free) begin
          w_examine = 1'b1;
          if (w_last) begin
            w_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_slot_free) begin
          w_drain_clear = 1'b1;
          w_next        = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The plane store only loads on an accepted start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf <= input_acts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dim     <= '0;
      r_idx     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_nnz     <= '0;
      r_valid   <= 1'b0;
      r_val     <= '0;
      r_out_idx <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
    end else begin
      if (w_capture) begin
        r_dim <= w_start_dim;
        r_idx <= '0;
        r_row <= '0;
        r_col <= '0;
        r_nnz <= '0;
      end
      if (w_examine) begin
        if (w_nz) begin
          r_valid   <= 1'b1;
          r_val     <= w_elem;
          r_out_idx <= r_idx;
          r_out_row <= r_row;
          r_out_col <= r_col;
          r_nnz     <= r_nnz + CNT_W'(1);
        end else begin
          r_valid <= 1'b0;
        end
        // Coordinates come from counters kept in step with idx; no divider.
        r_idx <= r_idx + IDX_W'(1);
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= r_row + RC_W'(1);
        end else begin
          r_col <= r_col + RC_W'(1);
        end
      end
      if (w_drain_clear) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign nnz_count = r_nnz;
  assign state_dbg = r_state;

  assign out_if.out_valid = r_valid;
  assign out_if.out_val   = r_val;
  assign out_if.out_idx   = r_out_idx;
  assign out_if.out_row   = r_out_row;
  assign out_if.out_col   = r_out_col;

endmodule

// File: tb/tb_scnn_act_compressor.sv
// Directed bench for scnn_act_compressor: sparse, empty, dense, backpressure,
// control corner cases and mid-pass reset.
module tb_scnn_act_compressor;
  localparam int SIZE  = 64;
  localparam int DIM   = 8;
  localparam int DW    = 16;
  localparam int IDX_W = 6;
  localparam int RC_W  = 3;
  localparam int CNT_W = 7;
  localparam int ENT_W = DW + IDX_W + 2 * RC_W;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [SIZE-1:0][DW-1:0]   input_acts;
  logic [7:0]                input_dim;
  logic                      busy;
  logic                      done;
  logic [CNT_W-1:0]          nnz_count;
  logic [1:0]                state_dbg;

  scnn_act_compressor_if #(.DATA_W(DW), .IDX_W(IDX_W), .RC_W(RC_W)) bus ();

  scnn_act_compressor #(
    .PARAM_IP_SIZE(SIZE),
    .PARAM_IP_DIM (DIM),
    .PARAM_DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .input_acts(input_acts),
    .input_dim (input_dim),
    .busy      (busy),
    .done      (done),
    .nnz_count (nnz_count),
    .state_dbg (state_dbg),
    .out_if    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [ENT_W-1:0] exp_q[$];
  logic [SIZE-1:0][DW-1:0] acts;
  logic [ENT_W-1:0] first_ent, last_ent, ent7;
  int done_edge, n_xfer, n_valid;

  int nz_i[21] = '{2, 4, 11, 13, 14, 17, 19, 25, 27, 30, 34, 35, 38, 41, 46, 49, 51, 53, 57, 59, 60};
  int nz_v[21] = '{2, 5, 11, 7, 4, 1, 3, 5, 2, 6, 4, 4, 3, 2, 1, 4, 2, 2, 1, 6, 3};

  function automatic logic [ENT_W-1:0] ent(input int v, input int i, input int r, input int c);
    return {DW'(v), IDX_W'(i), RC_W'(r), RC_W'(c)};
  endfunction

  function automatic logic [ENT_W-1:0] cur_ent();
    return {bus.out_val, bus.out_idx, bus.out_row, bus.out_col};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sparse();
    acts = '0;
    for (int k = 0; k < 21; k++) acts[nz_i[k]] = DW'(nz_v[k]);
  endtask

  task automatic build_exp(input int d);
    exp_q.delete();
    for (int i = 0; i < d * d; i++)
      if (acts[i] != '0) exp_q.push_back(ent(int'(acts[i]), i, i / d, i % d));
  endtask

  task automatic do_start(input int dim_in);
    @(negedge clk);
    input_acts = acts;
    input_dim  = 8'(dim_in);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Loop position e means "in the cycle after start-relative edge e".
  task automatic run_pass(input int bp, input int abort_at, input int busy_start_at);
    int bp_used;
    logic [ENT_W-1:0] exp_e;
    bp_used   = 0;
    done_edge = -1;
    n_xfer    = 0;
    n_valid   = 0;
    first_ent = '0;
    last_ent  = '0;
    ent7      = '0;
    for (int e = 0; e < 200; e++) begin
      if (e == abort_at) break;
      if (e == busy_start_at) begin
        start      = 1'b1;
        input_dim  = 8'd3;
        input_acts = '0;
      end else begin
        start = 1'b0;
      end
      if (bus.out_valid) n_valid++;
      if (bp != 0 && bus.out_valid && bus.out_idx == IDX_W'(11) && bp_used < 10) begin
        bus.out_ready = 1'b0;
        bp_used++;
        chk("bp_hold", cur_ent(), ent(11, 11, 1, 3));
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("xfer_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          chk("xfer_entry", cur_ent(), exp_e);
        end
        if (n_xfer == 0) first_ent = cur_ent();
        if (n_xfer == 7) ent7 = cur_ent();
        last_ent = cur_ent();
        n_xfer++;
      end
      if (done) begin
        done_edge = e;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (abort_at < 0) chk("done_seen", 32'(done_edge >= 0), 1);
  endtask

  task automatic after_done(input string tag, input int nnz_exp);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    chk({tag, "_nnz"}, 32'(nnz_count), nnz_exp);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'd0, done, busy}, 0);
    chk({tag, "_nnz_held"}, 32'(nnz_count), nnz_exp);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    input_acts = '0;
    input_dim = 8'd0;
    bus.out_ready = 1'b1;
    acts = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_entry", cur_ent(), 0);
    chk("rst_nnz", 32'(nnz_count), 0);
    chk("rst_state", 32'(state_dbg), 0);

    // Sparse 8x8
    set_sparse();
    build_exp(8);
    do_start(8);
    run_pass(0, -1, -1);
    chk("sparse_xfers", n_xfer, 21);
    chk("sparse_first", first_ent, ent(2, 2, 0, 2));
    chk("sparse_last", last_ent, ent(3, 60, 7, 4));
    chk("sparse_done_edge", done_edge, 65);
    after_done("sparse", 21);

    // All-zero plane
    acts = '0;
    build_exp(8);
    do_start(8);
    run_pass(0, -1, -1);
    chk("zero_valid_cycles", n_valid, 0);
    chk("zero_done_edge", done_edge, 65);
    after_done("zero", 0);

    // Dense 5x5; entries outside the 25 active ones must not be examined
    acts = '1;
    for (int i = 0; i < 25; i++) acts[i] = DW'(i + 1);
    build_exp(5);
    do_start(5);
    run_pass(0, -1, -1);
    chk("dense_xfers", n_xfer, 25);
    chk("dense_ent7", ent7, ent(8, 7, 1, 2));
    chk("dense_done_edge", done_edge, 26);
    after_done("dense", 25);

    // Backpressure on entry 11
    set_sparse();
    build_exp(8);
    do_start(8);
    run_pass(1, -1, -1);
    chk("bp_xfers", n_xfer, 21);
    chk("bp_done_edge", done_edge, 75);
    after_done("bp", 21);

    // start while busy is ignored
    set_sparse();
    build_exp(8);
    do_start(8);
    run_pass(0, -1, 20);
    chk("busy_start_xfers", n_xfer, 21);
    chk("busy_start_done_edge", done_edge, 65);
    after_done("busy_start", 21);

    // input_dim = 0 finishes immediately
    do_start(0);
    run_pass(0, -1, -1);
    chk("dim0_done_edge", done_edge, 0);
    chk("dim0_xfers", n_xfer, 0);
    after_done("dim0", 0);

    // input_dim = 12 clamps to 8; a start during DONE is ignored
    set_sparse();
    build_exp(8);
    do_start(12);
    run_pass(0, -1, -1);
    chk("dim12_xfers", n_xfer, 21);
    chk("dim12_done_edge", done_edge, 65);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", 32'(busy), 0);
    chk("start_in_done_nnz", 32'(nnz_count), 21);

    // Reset in the middle of a scan
    set_sparse();
    build_exp(8);
    do_start(8);
    run_pass(0, 30, -1);
    chk("mid_nnz_before_rst", 32'(nnz_count), 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_nnz", 32'(nnz_count), 0);
    build_exp(8);
    do_start(8);
    run_pass(0, -1, -1);
    chk("post_rst_xfers", n_xfer, 21);
    chk("post_rst_last", last_ent, ent(3, 60, 7, 4));
    chk("post_rst_done_edge", done_edge, 65);
    after_done("post_rst", 21);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
